apb_uart_cfg_master: RTL and testbench

//  APB initiator that drives the UART register block's APB port from a simple

---
 rtl/apb_uart_pkg.sv | 18 +
 rtl/apb_mst_timeout.sv | 30 +++
 rtl/apb_uart_cfg_master.sv | 124 ++++++++++++
 tb/tb_apb_uart_cfg_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared types and register map for the UART block's APB configuration path.
package apb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  localparam logic [31:0] REG_DIV      = 32'h0000_0000;
  localparam logic [31:0] REG_PARITY   = 32'h0000_0004;
  localparam logic [31:0] REG_STOP     = 32'h0000_0008;
  localparam logic [31:0] REG_ERR_RX   = 32'h0000_000C;
  localparam logic [31:0] REG_ERR_DROP = 32'h0000_0010;
  localparam logic [31:0] REG_ERR_STOP = 32'h0000_0014;

endpackage

// File: rtl/apb_mst_timeout.sv
// ACCESS-phase wait counter: cleared in SETUP, counts in ACCESS, flags the last allowed cycle.
module apb_mst_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // expire is asserted during the T-th ACCESS cycle, so the abort edge ends that cycle
  assign expire = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/apb_uart_cfg_master.sv
// APB initiator for the UART register block: one transfer at a time from a valid/ready command.
module apb_uart_cfg_master
  import apb_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          paddr,
  output logic [31:0]          pwdata,
  input  logic                 pready,
  input  logic [31:0]          prdata,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  apb_mst_state_t state_q, state_d;
  logic           pwrite_q;
  logic [31:0]    paddr_q, pwdata_q;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic           accept;
  logic           expire;
  logic           err_inc;

  apb_mst_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == SETUP),
    .enable(state_q == ACCESS),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_addr[1:0] != 2'b00) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout landing on the same cycle
        if (pready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = pwrite_q ? '0 : prdata;
        end else if (expire) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_inc = (state_d == RESP) && (state_q != RESP) && err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
      end
      if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_apb_uart_cfg_master.sv
// Randomized scoreboard bench for apb_uart_cfg_master with an APB slave memory model.
module tb_apb_uart_cfg_master;
  import apb_uart_pkg::*;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;
  logic [15:0] err_cnt;

  apb_uart_cfg_master #(
    .TIMEOUT_CYCLES(T),
    .ERR_CNT_W     (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- APB slave: answers after wait_n ACCESS cycles
  logic [31:0] mem [64];
  logic        init_done = 1'b0;
  int          wait_n = 0;
  int          acc_cyc = 0;
  logic        noise = 1'b0;
  logic [31:0] junk = '0;
  logic        ready_cyc;

  assign ready_cyc = psel && penable && (acc_cyc == wait_n);
  assign pready    = (psel && penable) ? ready_cyc : noise;
  assign prdata    = ready_cyc ? mem[paddr[7:2]] : junk;

  always @(posedge clk) begin
    acc_cyc <= (psel && penable) ? acc_cyc + 1 : 0;
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ready_cyc && pwrite) begin
      mem[paddr[7:2]] <= pwdata;
    end
  end

  always @(negedge clk) begin
    noise = 1'($urandom_range(0, 1));
    junk  = $urandom;
  end

  // ---------------- reference model and scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [15:0] cnt;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [64];
  logic [15:0] exp_errs = '0;
  logic        cur_write = 1'b0, cur_mis = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  int          hold_n = 0;

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int w);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL cmd_ready_wait: got 0 expected 1 within 100 cycles");
      return;
    end
    e.acc = cyc;
    e.rdata = '0;
    if (addr[1:0] != 2'b00) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (w >= int'(T)) begin
      e.err = 1'b1;
      e.lat = 2 + int'(T);
    end else begin
      e.err = 1'b0;
      e.lat = 3 + w;
      if (wr) ref_mem[addr[7:2]] = wd;
      else    e.rdata = ref_mem[addr[7:2]];
    end
    if (e.err && exp_errs != 16'hFFFF) exp_errs++;
    e.cnt = exp_errs;
    sb.push_back(e);
    cur_write = wr;
    cur_addr  = addr;
    cur_wdata = wd;
    cur_mis   = (addr[1:0] != 2'b00);
    wait_n    = w;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
  endtask

  // ---------------- monitor: protocol checks and response comparison
  logic        in_rsp = 1'b0, prev_hs = 1'b0, prev_psel = 1'b0, prev_pen = 1'b0;
  logic [31:0] held_rdata = '0;
  logic        held_err = 1'b0;
  int          vcnt = 0;
  exp_t        cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 1'b0;
      prev_hs = 1'b0;
      prev_psel = 1'b0;
      prev_pen = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
      end
      prev_hs = 1'b0;
      if (psel) begin
        chk("no_apb_when_misaligned", 32'(cur_mis), 32'd0);
        chk("paddr", paddr, cur_addr);
        chk("pwrite", 32'(pwrite), 32'(cur_write));
        if (cur_write) chk("pwdata", pwdata, cur_wdata);
      end
      if (prev_psel && !prev_pen) chk("setup_then_access", 32'({psel, penable}), 32'd3);
      if (psel && penable) chk("access_after_setup", 32'(prev_psel), 32'd1);
      prev_psel = psel;
      prev_pen  = penable;
      if (rsp_valid) begin
        chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        chk("paddr_held_in_resp", paddr, cur_addr);
        if (!in_rsp) begin
          in_rsp = 1'b1;
          vcnt = 0;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
          end else begin
            cur = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("err_cnt", 32'(err_cnt), 32'(cur.cnt));
          end
          held_rdata = rsp_rdata;
          held_err   = rsp_err;
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, held_rdata);
          chk("rsp_err_stable", 32'(rsp_err), 32'(held_err));
        end
        rsp_ready = (vcnt < hold_n) ? 1'b0 : ($urandom_range(0, 2) != 0);
        vcnt++;
        if (rsp_ready) begin
          in_rsp  = 1'b0;
          prev_hs = 1'b1;
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- stimulus
  initial begin
    int n;
    logic [31:0] a;
    int w;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    init_done = 1'b1;
    rst_n = 1'b1;

    issue(1'b1, REG_DIV, 32'h0000_01B2, 0);
    drain();
    chk("slave_div", mem[0], 32'h0000_01B2);
    issue(1'b1, REG_PARITY, 32'h5, 0);
    issue(1'b0, REG_PARITY, 32'h0, 3);
    issue(1'b0, REG_STOP, 32'h0, 99);
    issue(1'b0, REG_ERR_RX, 32'h0, int'(T) - 1);
    issue(1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 0);
    drain();
    hold_n = 5;
    issue(1'b0, REG_DIV, 32'h0, 1);
    drain();
    hold_n = 0;

    // reset in the middle of an ACCESS phase
    issue(1'b0, REG_ERR_DROP, 32'h0, 99);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_access", 32'(psel && penable), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    sb.delete();
    exp_errs = '0;
    rst_n = 1'b1;
    issue(1'b1, REG_STOP, 32'h0000_0002, 1);
    issue(1'b0, REG_STOP, 32'h0, 0);
    drain();

    for (int k = 0; k < 150; k++) begin
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3))
                                     : (($urandom_range(0, 1) != 0) ? int'(T) - 1 : 99);
      issue(1'($urandom_range(0, 1)), a, $urandom, w);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
